pc_call_stack: RTL

PC_CALL_STACK -- requirements
Module: pc_call_stack

---
 rtl/pc_call_stack.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pc_call_stack.sv
// Nibble-serial program counter with a circular return-address stack.
// The PC increments over cycles 0..NIBBLES-1; pushes, pops and nibble loads happen in cycles 3..7.
module pc_call_stack #(
    parameter int unsigned NIBBLES = 3,
    parameter int unsigned DEPTH   = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               halt,
    input  logic [2:0]         cycle,
    input  logic [1:0]         stack_op,
    input  logic [1:0]         pc_next_sel,
    input  logic [3:0]         data,
    input  logic [3:0]         regval,
    input  logic [NIBBLES-1:0] pc_write_enable,
    output logic               pc_enable,
    output logic [3:0]         pc_word,
    output logic [3:0]         stack_count,
    output logic               overflow,
    output logic               underflow
);
    localparam int unsigned    PcW       = 4 * NIBBLES;
    localparam int unsigned    SpW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SpW-1:0] SpLast    = SpW'(DEPTH - 1);
    localparam logic [3:0]     CountFull = 4'(DEPTH);
    localparam logic [1:0]     OpPush    = 2'b01;
    localparam logic [1:0]     OpPop     = 2'b10;

    logic [PcW-1:0] pc_q, pc_d;
    logic           carry_q, carry_d;
    logic [SpW-1:0] sp_q, sp_d;
    logic [3:0]     count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic [PcW-1:0] stack_q [DEPTH];

    logic [SpW-1:0] sp_next, sp_prev;
    logic           op_cycle, do_push, do_pop, load_phase;
    logic [3:0]     load_val;
    logic [4:0]     sum;
    logic           cin;
    logic           found;

    assign sp_next    = (sp_q == SpLast) ? '0 : sp_q + SpW'(1);
    assign sp_prev    = (sp_q == '0) ? SpLast : sp_q - SpW'(1);
    assign op_cycle   = !halt && (cycle == 3'd3);
    assign do_push    = op_cycle && (stack_op == OpPush);
    assign do_pop     = op_cycle && (stack_op == OpPop);
    assign load_phase = !halt && (cycle >= 3'd3);

    always_comb begin
        case (pc_next_sel)
            2'b00:   load_val = data;
            2'b01:   load_val = regval;
            default: load_val = 4'h0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        carry_d = carry_q;
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        sum     = '0;
        cin     = 1'b0;
        found   = 1'b0;

        // Ripple increment, one nibble per phase; carry out of the top nibble is dropped.
        if (!halt) begin
            for (int unsigned k = 0; k < NIBBLES; k++) begin
                if (cycle == 3'(k)) begin
                    cin                = (k == 0) ? 1'b1 : carry_q;
                    sum                = {1'b0, pc_q[4*k +: 4]} + {4'd0, cin};
                    pc_d[4*k +: 4]     = sum[3:0];
                    carry_d            = sum[4];
                end
            end
        end

        if (do_pop) begin
            if (count_q != 4'd0) begin
                pc_d    = stack_q[sp_prev];
                sp_d    = sp_prev;
                count_d = count_q - 4'd1;
            end else begin
                udf_d = 1'b1;
            end
        end else if (load_phase) begin
            // Only the lowest set strobe bit loads its nibble.
            for (int unsigned k = 0; k < NIBBLES; k++) begin
                if (!found && pc_write_enable[k]) begin
                    pc_d[4*k +: 4] = load_val;
                    found          = 1'b1;
                end
            end
        end

        if (do_push) begin
            sp_d = sp_next;
            if (count_q == CountFull) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            carry_q <= 1'b0;
            sp_q    <= '0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            carry_q <= carry_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Stack captures the PC before any same-cycle nibble load.
    always_ff @(posedge clock) begin
        if (do_push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    always_comb begin
        pc_enable = (cycle < 3'd3);
        pc_word   = 4'h0;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (cycle == 3'(k)) begin
                pc_word = pc_q[4*k +: 4];
            end
        end
    end

    assign stack_count = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule
